// File: rtl/rockets_pkg.sv
// rtl/rockets_pkg.sv - shared constants, coordinate type and FSM states for the rocket movers
package rockets_pkg;

    localparam int FRAC_BITS_DEF     = 6;
    localparam int TOP_BORDER_DEF    = 0;
    localparam int BOTTOM_BORDER_DEF = 479;
    localparam int ROCKET_HEIGHT_DEF = 16;

    typedef logic signed [10:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FLYING = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rocket_mover_if.sv
// rtl/rocket_mover_if.sv - controller <-> rocket mover signal bundle
import rockets_pkg::*;

interface rocket_mover_if;
    logic   startOfFrame;
    logic   isActive;
    coord_t initialX;
    coord_t initialY;
    coord_t initialSpeed;
    coord_t rocketTLX;
    coord_t rocketTLY;
    logic   rocketVisible;
    logic   reachedBorder;

    modport master (
        output startOfFrame, isActive, initialX, initialY, initialSpeed,
        input  rocketTLX, rocketTLY, rocketVisible, reachedBorder
    );

    modport slave (
        input  startOfFrame, isActive, initialX, initialY, initialSpeed,
        output rocketTLX, rocketTLY, rocketVisible, reachedBorder
    );
endinterface

// File: rtl/rocket_mover.sv
// rtl/rocket_mover.sv - per-rocket launch latch, per-frame vertical motion and border exit pulse
import rockets_pkg::*;

module rocket_mover #(
    parameter int FRAC_BITS     = FRAC_BITS_DEF,
    parameter int TOP_BORDER    = TOP_BORDER_DEF,
    parameter int BOTTOM_BORDER = BOTTOM_BORDER_DEF,
    parameter int ROCKET_HEIGHT = ROCKET_HEIGHT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    rocket_mover_if.slave  bus
);

    localparam int YW = 11 + FRAC_BITS;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_active_d;
    logic                   r_check;
    logic signed [YW-1:0]   r_y;
    logic signed [YW-1:0]   r_speed;
    coord_t                 r_x;

    coord_t                 w_tly;
    logic                   w_border;
    logic                   w_load;
    logic                   w_step;
    logic                   w_pulse;
    logic                   w_visible;

    assign w_tly    = coord_t'(r_y >>> FRAC_BITS);
    assign w_border = (int'(w_tly) < TOP_BORDER) ||
                      (int'(w_tly) + ROCKET_HEIGHT > BOTTOM_BORDER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort (isActive low) outranks both the border check and frame updates.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_pulse   = 1'b0;
        w_visible = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.isActive && !r_active_d) begin
                    w_next = LAUNCH;
                end
            end
            LAUNCH: begin
                if (bus.isActive) begin
                    w_load = 1'b1;
                    w_next = FLYING;
                end else begin
                    w_next = IDLE;
                end
            end
            FLYING: begin
                w_visible = 1'b1;
                if (!bus.isActive) begin
                    w_next = IDLE;
                end else if (r_check && w_border) begin
                    w_pulse = 1'b1;
                    w_next  = DONE;
                end else if (bus.startOfFrame) begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                if (!bus.isActive) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // r_check marks the cycle right after a position update, when the border is judged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active_d <= 1'b0;
            r_check    <= 1'b0;
            r_y        <= '0;
            r_speed    <= '0;
            r_x        <= '0;
        end else begin
            r_active_d <= bus.isActive;
            r_check    <= w_step;
            if (w_load) begin
                r_y     <= {bus.initialY, {FRAC_BITS{1'b0}}};
                r_speed <= {{FRAC_BITS{bus.initialSpeed[10]}}, bus.initialSpeed};
                r_x     <= bus.initialX;
            end else if (w_step) begin
                r_y <= r_y + r_speed;
            end
        end
    end

    assign bus.rocketTLX     = r_x;
    assign bus.rocketTLY     = w_tly;
    assign bus.rocketVisible = w_visible;
    assign bus.reachedBorder = w_pulse;

endmodule

// File: tb/tb_rocket_mover.sv
// tb/tb_rocket_mover.sv - self-checking bench for rocket_mover
import rockets_pkg::*;

module tb_rocket_mover;

    logic   clk;
    logic   reset;
    logic   sof;
    logic   act;
    coord_t ix;
    coord_t iy;
    coord_t isp;

    rocket_mover_if bus ();

    assign bus.startOfFrame = sof;
    assign bus.isActive     = act;
    assign bus.initialX     = ix;
    assign bus.initialY     = iy;
    assign bus.initialSpeed = isp;

    rocket_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // values sampled from the DUT at the most recent negedge
    int   s_tly;
    int   s_tlx;
    logic s_vis;
    logic s_pulse;

    // reference model of one rocket's flight
    bit m_launch, m_fly, m_done, m_check, m_prev;
    int m_y, m_v, m_x;

    typedef struct {
        logic sof;
        logic act;
        int   tly;
        logic vis;
        logic pulse;
        int   tlx;
    } vec_t;
    vec_t vecs[$];

    function automatic int fdiv64(int y);
        return (y >= 0) ? (y / 64) : -((-y + 63) / 64);
    endfunction

    function automatic bit off_field(int tly);
        return (tly < 0) || (tly + 16 > 479);
    endfunction

    task automatic chk(string name, int actual, int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_clear();
        m_launch = 0; m_fly = 0; m_done = 0; m_check = 0; m_prev = 0;
        m_y = 0; m_v = 0; m_x = 0;
    endtask

    task automatic apply_reset(logic val);
        reset = val;
        if (val) model_clear();
    endtask

    // One clock: compare at negedge, advance model at posedge, return just after the edge.
    task automatic tick();
        bit exp_pulse;
        bit chk_next;
        @(negedge clk);
        s_tly   = int'(bus.rocketTLY);
        s_tlx   = int'(bus.rocketTLX);
        s_vis   = bus.rocketVisible;
        s_pulse = bus.reachedBorder;
        exp_pulse = m_fly && m_check && act && off_field(fdiv64(m_y));
        chk("model_tly",   s_tly,        fdiv64(m_y));
        chk("model_tlx",   s_tlx,        m_x);
        chk("model_vis",   int'(s_vis),  int'(m_fly));
        chk("model_pulse", int'(s_pulse), int'(exp_pulse));
        @(posedge clk);
        chk_next = 0;
        if (reset) begin
            model_clear();
        end else begin
            if (m_launch) begin
                m_launch = 0;
                if (act) begin
                    m_y = int'(iy) * 64; m_v = int'(isp); m_x = int'(ix); m_fly = 1;
                end
            end else if (m_fly) begin
                if (!act) m_fly = 0;
                else if (exp_pulse) begin m_fly = 0; m_done = 1; end
                else if (sof) begin m_y = m_y + m_v; chk_next = 1; end
            end else if (m_done) begin
                if (!act) m_done = 0;
            end else if (act && !m_prev) begin
                m_launch = 1;
            end
            m_check = chk_next;
            m_prev  = act;
        end
        #1;
    endtask

    task automatic cyc(logic f, logic a);
        sof = f; act = a;
        tick();
    endtask

    // a startOfFrame cycle followed by a quiet cycle; sampled values reflect the new position
    task automatic frame(logic a);
        cyc(1'b1, a);
        cyc(1'b0, a);
    endtask

    task automatic launch(int x, int y, int v);
        ix = 11'(x); iy = 11'(y); isp = 11'(v);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
    endtask

    task automatic add_vec(logic f, logic a, int tly, logic vis, logic pulse, int tlx);
        vec_t v;
        v.sof = f; v.act = a; v.tly = tly; v.vis = vis; v.pulse = pulse; v.tlx = tlx;
        vecs.push_back(v);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sof = 0; act = 0; ix = '0; iy = '0; isp = '0;
        model_clear();
        apply_reset(1'b1);
        #2;
        chk("reset_tly",   int'(bus.rocketTLY), 0);
        chk("reset_tlx",   int'(bus.rocketTLX), 0);
        chk("reset_vis",   int'(bus.rocketVisible), 0);
        chk("reset_pulse", int'(bus.reachedBorder), 0);
        tick();
        tick();
        apply_reset(1'b0);
        tick();

        // player shot: Y=4, -2 px/frame, X=100
        ix = 11'(100); iy = 11'(4); isp = -11'sd128;
        add_vec(0, 0,  0, 0, 0,   0);
        add_vec(0, 1,  0, 0, 0,   0);
        add_vec(0, 1,  0, 0, 0,   0);
        add_vec(0, 1,  4, 1, 0, 100);
        add_vec(1, 1,  4, 1, 0, 100);
        add_vec(0, 1,  2, 1, 0, 100);
        add_vec(1, 1,  2, 1, 0, 100);
        add_vec(0, 1,  0, 1, 0, 100);
        add_vec(1, 1,  0, 1, 0, 100);
        add_vec(0, 1, -2, 1, 1, 100);
        add_vec(0, 1, -2, 0, 0, 100);
        add_vec(0, 0, -2, 0, 0, 100);
        add_vec(0, 0, -2, 0, 0, 100);
        foreach (vecs[i]) begin
            cyc(vecs[i].sof, vecs[i].act);
            chk($sformatf("player_tly[%0d]", i),   s_tly,          vecs[i].tly);
            chk($sformatf("player_vis[%0d]", i),   int'(s_vis),    int'(vecs[i].vis));
            chk($sformatf("player_pulse[%0d]", i), int'(s_pulse),  int'(vecs[i].pulse));
            chk($sformatf("player_tlx[%0d]", i),   s_tlx,          vecs[i].tlx);
        end

        // alien shot: Y=460, +0.5 px/frame, exits after frame 8
        launch(300, 460, 32);
        chk("alien_tly0", s_tly, 460);
        chk("alien_vis0", int'(s_vis), 1);
        for (int f = 1; f <= 8; f++) begin
            frame(1'b1);
            chk($sformatf("alien_tly_f%0d", f),   s_tly,         460 + f / 2);
            chk($sformatf("alien_pulse_f%0d", f), int'(s_pulse), (f == 8) ? 1 : 0);
        end

        // re-arm: isActive held high in DONE never relaunches
        for (int f = 0; f < 10; f++) begin
            frame(1'b1);
            chk("rearm_hold_vis",   int'(s_vis),   0);
            chk("rearm_hold_pulse", int'(s_pulse), 0);
            chk("rearm_hold_tly",   s_tly,         464);
        end
        cyc(1'b0, 1'b0);
        launch(50, 200, 32);
        chk("rearm_tly", s_tly, 200);
        chk("rearm_vis", int'(s_vis), 1);

        // abort at frame 5 of an alien shot
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        launch(300, 460, 32);
        for (int f = 1; f <= 4; f++) frame(1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("abort_pulse0", int'(s_pulse), 0);
        for (int k = 0; k < 12; k++) begin
            cyc((k % 3) == 0, 1'b0);
            chk("abort_vis",   int'(s_vis),   0);
            chk("abort_pulse", int'(s_pulse), 0);
        end

        // race: isActive drops exactly when the border would be flagged
        launch(300, 460, 32);
        for (int f = 1; f <= 7; f++) frame(1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("race_pulse", int'(s_pulse), 0);
        cyc(1'b0, 1'b0);
        chk("race_vis",   int'(s_vis),   0);
        chk("race_pulse2", int'(s_pulse), 0);

        // asynchronous reset mid-flight
        launch(100, 4, -128);
        frame(1'b1);
        frame(1'b1);
        cyc(1'b1, 1'b1);
        apply_reset(1'b1);
        #1;
        chk("rst_mid_tly",   int'(bus.rocketTLY), 0);
        chk("rst_mid_tlx",   int'(bus.rocketTLX), 0);
        chk("rst_mid_vis",   int'(bus.rocketVisible), 0);
        chk("rst_mid_pulse", int'(bus.reachedBorder), 0);
        act = 0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        apply_reset(1'b0);
        for (int f = 0; f < 3; f++) begin
            frame(1'b0);
            chk("rst_idle_tly", s_tly, 0);
            chk("rst_idle_vis", int'(s_vis), 0);
        end
        launch(7, 4, -128);
        chk("rst_relaunch_tly", s_tly, 4);
        chk("rst_relaunch_tlx", s_tlx, 7);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            sof = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 39) == 0) act = ~act;
            ix  = 11'($urandom_range(0, 2047));
            isp = 11'(int'($urandom_range(0, 512)) - 256);
            r = int'($urandom_range(0, 3));
            if (r == 0)      iy = 11'(int'($urandom_range(0, 25)) - 5);
            else if (r == 1) iy = 11'($urandom_range(440, 470));
            else             iy = 11'(int'($urandom_range(0, 700)) - 100);
            if ($urandom_range(0, 399) == 0) begin
                apply_reset(1'b1);
                tick();
                apply_reset(1'b0);
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
